// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract round-robin arbiter.
// Tag ids are carried at the widest supported width (16 requesters).
package addsub_pkg;
  localparam logic OP_ADD     = 1'b0;
  localparam logic OP_SUB     = 1'b1;
  localparam int   ADDSUB_LAT = 2;
  localparam int   TAG_IDW    = 4;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;
endpackage

// File: rtl/addsub_rr_pick.sv
// Combinational rotating-priority picker: first set bit of req at or above
// ptr, wrapping at NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            found
);
  always_comb begin
    int             j;
    logic [IDW-1:0] jj;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    jj     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IDW'(j);
      if (!found && req[jj]) begin
        found      = 1'b1;
        onehot[jj] = 1'b1;
        idx        = jj;
      end
    end
  end
endmodule

// File: rtl/addsub_rr_arbiter.sv
// Round-robin sequencer sharing one external registered add/sub datapath.
// ADDSUB_ARB_PERF_EN adds per-requester grant counters and a busy-cycle count.
module addsub_rr_arbiter
  import addsub_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int LAT  = ADDSUB_LAT,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_op,
  input  logic [NREQ-1:0] req_cin,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0] gnt,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic            alu_cin,
  output logic            alu_cnt,
  input  logic [N-1:0]    alu_s,
  input  logic            alu_cout,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [N-1:0]    rsp_s,
  output logic            rsp_cout
`ifdef ADDSUB_ARB_PERF_EN
  ,
  output logic [NREQ*16-1:0] gnt_cnt,
  output logic [31:0]        busy_cycles
`endif
);
  logic [NREQ-1:0] gnt_q, gnt_d, eff_req, win_oh;
  logic [IDW-1:0]  ptr_q, ptr_d, win_idx, rsp_id_q, rsp_id_d;
  logic            win_any;
  logic [N-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_s_q, rsp_s_d;
  logic            alu_cin_q, alu_cin_d, alu_cnt_q, alu_cnt_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_cout_q, rsp_cout_d;
  tag_t [LAT:0]    tag_q, tag_d;
  logic            tag_id_unused;

  // A requester's own grant masks it for one cycle so it can drop req.
  assign eff_req = req & ~gnt_q;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req(eff_req), .ptr(ptr_q), .onehot(win_oh), .idx(win_idx), .found(win_any)
  );

  always_comb begin
    gnt_d       = '0;
    ptr_d       = ptr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    alu_cnt_d   = alu_cnt_q;
    tag_d       = '0;
    rsp_valid_d = tag_q[LAT].valid;
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    rsp_cout_d  = rsp_cout_q;
    if (win_any) begin
      gnt_d    = win_oh;
      ptr_d    = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
      tag_d[0] = '{valid: 1'b1, id: TAG_IDW'(win_idx)};
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        alu_a_d   = req_a[i*N +: N];
        alu_b_d   = req_b[i*N +: N];
        alu_cin_d = req_cin[i];
        alu_cnt_d = req_op[i] ? OP_SUB : OP_ADD;
      end
    end
    for (int s = 1; s <= LAT; s++) tag_d[s] = tag_q[s-1];
    if (tag_q[LAT].valid) begin
      rsp_id_d   = tag_q[LAT].id[IDW-1:0];
      rsp_s_d    = alu_s;
      rsp_cout_d = alu_cout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q       <= '0;
      ptr_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_cnt_q   <= 1'b0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      alu_cnt_q   <= alu_cnt_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  // Tag ids are stored wider than IDW; the upper bits are always zero.
  assign tag_id_unused = ^tag_q[LAT].id;

  assign gnt       = gnt_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign alu_cnt   = alu_cnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_cout  = rsp_cout_q;

`ifdef ADDSUB_ARB_PERF_EN
  logic [NREQ-1:0][15:0] gnt_cnt_q, gnt_cnt_d;
  logic [31:0]           busy_cycles_q, busy_cycles_d;

  always_comb begin
    busy_cycles_d = busy_cycles_q + {31'b0, tag_q[0].valid};
    for (int i = 0; i < NREQ; i++)
      gnt_cnt_d[i] = (gnt_q[i] && gnt_cnt_q[i] != 16'hFFFF) ? gnt_cnt_q[i] + 16'd1
                                                            : gnt_cnt_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_cnt_q     <= '0;
      busy_cycles_q <= '0;
    end else begin
      gnt_cnt_q     <= gnt_cnt_d;
      busy_cycles_q <= busy_cycles_d;
    end
  end

  assign gnt_cnt     = gnt_cnt_q;
  assign busy_cycles = busy_cycles_q;
`endif
endmodule
